// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: optional dirty-victim writeback followed by a
// line fill, one word per acked bus cycle over a simple req/ack memory port.
module cache_refill_ctrl #(
    parameter int unsigned BLOCK_SIZE = 16,
    localparam int unsigned N  = BLOCK_SIZE / 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          miss_req,
    input  logic [31:0]   miss_addr,
    input  logic          victim_dirty,
    input  logic [31:0]   victim_addr,
    output logic [IW-1:0] victim_rd_idx,
    input  logic [31:0]   victim_rd_data,
    output logic          fill_we,
    output logic [IW-1:0] fill_idx,
    output logic [31:0]   fill_data,
    output logic [31:0]   fill_addr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} state_t;

    localparam logic [31:0]   OffsMask = 32'(BLOCK_SIZE - 1);
    localparam logic [IW-1:0] LastIdx  = IW'(N - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] k_q, k_d;
    logic [31:0]   miss_base_q, miss_base_d;
    logic [31:0]   victim_base_q, victim_base_d;
    logic          fill_we_q, fill_we_d;
    logic [IW-1:0] fill_idx_q, fill_idx_d;
    logic [31:0]   fill_data_q, fill_data_d;
    logic [31:0]   word_offs;

    assign word_offs = 32'(k_q) << 2;

    // Next-state, word counter and bus outputs; acks only count while mem_req is high.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        miss_base_d   = miss_base_q;
        victim_base_d = victim_base_q;
        fill_we_d     = 1'b0;
        fill_idx_d    = '0;
        fill_data_d   = '0;
        victim_rd_idx = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        unique case (state_q)
            StIdle: begin
                if (miss_req) begin
                    miss_base_d   = miss_addr & ~OffsMask;
                    victim_base_d = victim_addr & ~OffsMask;
                    k_d           = '0;
                    state_d       = victim_dirty ? StWb : StFill;
                end
            end
            StWb: begin
                mem_req       = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = victim_base_q + word_offs;
                victim_rd_idx = k_q;
                mem_wdata     = victim_rd_data;
                if (mem_ack) begin
                    if (k_q == LastIdx) begin
                        k_d     = '0;
                        state_d = StFill;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
            end
            StFill: begin
                mem_req  = 1'b1;
                mem_addr = miss_base_q + word_offs;
                if (mem_ack) begin
                    fill_we_d   = 1'b1;
                    fill_idx_d  = k_q;
                    fill_data_d = mem_rdata;
                    if (k_q == LastIdx) begin
                        k_d     = '0;
                        state_d = StDone;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered fill-port outputs; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            k_q           <= '0;
            miss_base_q   <= '0;
            victim_base_q <= '0;
            fill_we_q     <= 1'b0;
            fill_idx_q    <= '0;
            fill_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            miss_base_q   <= miss_base_d;
            victim_base_q <= victim_base_d;
            fill_we_q     <= fill_we_d;
            fill_idx_q    <= fill_idx_d;
            fill_data_q   <= fill_data_d;
        end
    end

    assign fill_we   = fill_we_q;
    assign fill_idx  = fill_idx_q;
    assign fill_data = fill_data_q;
    assign fill_addr = fill_we_q ? miss_base_q : 32'd0;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: inputs driven and outputs sampled on
// the falling edge; memory read data and victim words come from fixed patterns.
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        victim_dirty;
    logic [31:0] victim_addr;
    logic [1:0]  victim_rd_idx;
    logic [31:0] victim_rd_data;
    logic        fill_we;
    logic [1:0]  fill_idx;
    logic [31:0] fill_data;
    logic [31:0] fill_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] RdMask = 32'hF0F0_0000;

    // Memory returns its address xor a mask; the victim line holds BEEF_000<idx>.
    assign mem_rdata      = mem_addr ^ RdMask;
    assign victim_rd_data = 32'hBEEF_0000 | {30'd0, victim_rd_idx};

    always #5 clk = ~clk;

    cache_refill_ctrl #(.BLOCK_SIZE(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .miss_req      (miss_req),
        .miss_addr     (miss_addr),
        .victim_dirty  (victim_dirty),
        .victim_addr   (victim_addr),
        .victim_rd_idx (victim_rd_idx),
        .victim_rd_data(victim_rd_data),
        .fill_we       (fill_we),
        .fill_idx      (fill_idx),
        .fill_data     (fill_data),
        .fill_addr     (fill_addr),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int          fills, dones, wr_acks, rd_acks;
    logic        prev_req, prev_ack, prev_we;
    logic [31:0] prev_addr, prev_wdata;

    initial begin
        rst = 1'b1; miss_req = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
        victim_addr = '0; mem_ack = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fill_we", 32'(fill_we), 0);
        chk("rst_mem_req", 32'(mem_req), 0);

        // Spurious acks while idle
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_ack_busy", 32'(busy), 0);
            chk("idle_ack_fill_we", 32'(fill_we), 0);
            chk("idle_ack_mem_req", 32'(mem_req), 0);
        end

        // Clean miss, zero-wait memory
        miss_addr = 32'h0000_1234; victim_dirty = 1'b0; miss_req = 1'b1;
        step();
        miss_req = 1'b0;
        chk("clean_busy", 32'(busy), 1);
        chk("clean_we", 32'(mem_we), 0);
        chk("clean_addr0", mem_addr, 32'h1230);
        chk("clean_wdata", mem_wdata, 0);
        chk("clean_vidx", 32'(victim_rd_idx), 0);
        chk("clean_no_fill", 32'(fill_we), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("clean_fill_we", 32'(fill_we), 1);
            chk("clean_fill_idx", 32'(fill_idx), 32'(i));
            chk("clean_fill_data", fill_data, (32'h1230 + 32'(4 * i)) ^ RdMask);
            chk("clean_fill_addr", fill_addr, 32'h1230);
            if (i < 3) begin
                chk("clean_addr", mem_addr, 32'h1230 + 32'(4 * (i + 1)));
                chk("clean_not_done", 32'(done), 0);
            end else begin
                chk("clean_done", 32'(done), 1);
                chk("clean_done_req", 32'(mem_req), 0);
            end
        end
        step();
        chk("clean_idle", 32'(busy), 0);
        chk("clean_done_1cyc", 32'(done), 0);
        chk("clean_fill_off", 32'(fill_we), 0);
        chk("clean_fill_idx0", 32'(fill_idx), 0);

        // Dirty miss, zero-wait memory
        victim_addr = 32'h0000_8008; miss_addr = 32'h0000_0040; victim_dirty = 1'b1;
        miss_req = 1'b1;
        step();
        miss_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            chk("wb_we", 32'(mem_we), 1);
            chk("wb_addr", mem_addr, 32'h8000 + 32'(4 * i));
            chk("wb_vidx", 32'(victim_rd_idx), 32'(i));
            chk("wb_wdata", mem_wdata, 32'hBEEF_0000 + 32'(i));
            chk("wb_no_fill", 32'(fill_we), 0);
        end
        step();
        chk("dfill_we", 32'(mem_we), 0);
        chk("dfill_addr0", mem_addr, 32'h40);
        chk("dfill_wdata", mem_wdata, 0);
        chk("dfill_vidx", 32'(victim_rd_idx), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dfill_fill_we", 32'(fill_we), 1);
            chk("dfill_fill_idx", 32'(fill_idx), 32'(i));
            chk("dfill_fill_data", fill_data, (32'h40 + 32'(4 * i)) ^ RdMask);
            chk("dfill_done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
        end
        step();
        chk("dirty_idle", 32'(busy), 0);

        // Wait states: ack every third cycle, dirty miss
        mem_ack = 1'b0;
        victim_addr = 32'h0000_3004; miss_addr = 32'h0000_2004; victim_dirty = 1'b1;
        miss_req = 1'b1;
        step();
        miss_req = 1'b0;
        fills = 0; dones = 0; wr_acks = 0; rd_acks = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wdata = '0;
        for (int c = 0; c < 40; c++) begin
            if (fill_we) fills++;
            if (done) dones++;
            if (prev_req && !prev_ack) begin
                chk("ws_hold_req", 32'(mem_req), 1);
                chk("ws_hold_we", 32'(mem_we), 32'(prev_we));
                chk("ws_hold_addr", mem_addr, prev_addr);
                chk("ws_hold_wdata", mem_wdata, prev_wdata);
            end
            mem_ack = (c % 3 == 2);
            if (mem_req && mem_ack) begin
                if (mem_we) wr_acks++;
                else rd_acks++;
            end
            prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we;
            prev_addr = mem_addr; prev_wdata = mem_wdata;
            step();
        end
        mem_ack = 1'b0;
        chk("ws_fills", 32'(fills), 4);
        chk("ws_dones", 32'(dones), 1);
        chk("ws_writes", 32'(wr_acks), 4);
        chk("ws_reads", 32'(rd_acks), 4);
        chk("ws_idle", 32'(busy), 0);

        // miss_req held through refill; a pulse while busy is dropped
        mem_ack = 1'b1; victim_dirty = 1'b0; miss_addr = 32'h0000_4000; miss_req = 1'b1;
        step();
        miss_addr = 32'h0000_5010;
        chk("hold_addr0", mem_addr, 32'h4000);
        repeat (4) step();
        chk("hold_done", 32'(done), 1);
        chk("hold_fill_addr", fill_addr, 32'h4000);
        step();
        chk("hold_idle_gap", 32'(busy), 0);
        step();
        chk("hold_restart", 32'(busy), 1);
        chk("hold_addr1", mem_addr, 32'h5010 & ~32'hF);
        miss_req = 1'b0;
        step();
        miss_addr = 32'h0000_6000; miss_req = 1'b1;
        step();
        miss_req = 1'b0;
        step(); step();
        chk("hold_done2", 32'(done), 1);
        chk("hold_fill_addr2", fill_addr, 32'h5010 & ~32'hF);
        step();
        chk("pulse_dropped_a", 32'(busy), 0);
        step();
        chk("pulse_dropped_b", 32'(busy), 0);
        chk("pulse_dropped_req", 32'(mem_req), 0);

        // Reset after the second fill ack
        miss_addr = 32'h0000_7000; miss_req = 1'b1;
        step();
        miss_req = 1'b0;
        step(); step();
        chk("rstmid_fill_idx", 32'(fill_idx), 1);
        rst = 1'b1;
        step();
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_req", 32'(mem_req), 0);
        chk("rstmid_fill_we", 32'(fill_we), 0);
        chk("rstmid_done", 32'(done), 0);
        rst = 1'b0;
        step();
        chk("rstmid_fill_we2", 32'(fill_we), 0);
        chk("rstmid_busy2", 32'(busy), 0);
        miss_addr = 32'h0000_7104; miss_req = 1'b1;
        step();
        miss_req = 1'b0;
        chk("fresh_addr0", mem_addr, 32'h7100);
        repeat (3) step();
        chk("fresh_fill_idx2", 32'(fill_idx), 2);
        step();
        chk("fresh_done", 32'(done), 1);
        chk("fresh_fill_idx3", 32'(fill_idx), 3);
        chk("fresh_fill_data", fill_data, 32'h710C ^ RdMask);
        chk("fresh_fill_addr", fill_addr, 32'h7100);
        step();
        chk("fresh_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 16, meaning line size in bytes; N = BLOCK_SIZE/4 words per line; IW = $clog2(N) (2 at default).
REQ-002 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port miss_req  input  1  cache requests a line refill.
REQ-005 SHALL have port miss_addr  input  32  address that missed.
REQ-006 SHALL have port victim_dirty  input  1  line being replaced is dirty.
REQ-007 SHALL have port victim_addr  input  32  any address within the victim line.
REQ-008 SHALL have port victim_rd_idx  output  IW  word index of the victim read.
REQ-009 SHALL have port victim_rd_data  input  32  victim word, combinational from victim_rd_idx.
REQ-010 SHALL have ports fill_we  output  1, fill_idx  output  IW, fill_data  output  32, fill_addr  output  32  for line writes into the cache.
REQ-011 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32, mem_ack  input  1, mem_rdata  input  32  for the word memory bus.
REQ-012 SHALL have ports busy  output  1  and done  output  1.

Function
REQ-013 SHALL implement FSM states IDLE, WB, FILL, DONE; busy = (state != IDLE).
REQ-014 In IDLE, miss_req=1 SHALL latch line bases miss_base = miss_addr & ~(BLOCK_SIZE-1) and victim_base = victim_addr & ~(BLOCK_SIZE-1), clear word counter k, and go to WB if victim_dirty=1, else FILL.
REQ-015 miss_req SHALL be ignored in any state other than IDLE; no queuing.
REQ-016 In WB: mem_req=1, mem_we=1, mem_addr=victim_base+4k, victim_rd_idx=k, mem_wdata=victim_rd_data.
REQ-017 In FILL: mem_req=1, mem_we=0, mem_addr=miss_base+4k, mem_wdata=0.
REQ-018 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until the cycle in which mem_ack=1; k increments on each acked cycle; one ack per cycle maximum, zero-wait acks supported.
REQ-019 On the ack with k=N-1, k SHALL wrap to 0; WB goes to FILL, FILL goes to DONE.
REQ-020 On each FILL ack, the next cycle SHALL assert fill_we=1 for one cycle with fill_idx=acked k, fill_data=registered mem_rdata, fill_addr=miss_base.
REQ-021 DONE SHALL last exactly one cycle with done=1 and then return to IDLE; the last fill_we coincides with DONE.
REQ-022 mem_ack SHALL be ignored when mem_req=0 (IDLE, DONE).
REQ-023 Latency with zero-wait memory, miss_req accepted at edge T: clean miss gives fill_we at T+2..T+N+1 and done at T+N+1; a dirty miss adds N cycles.
REQ-024 Outside WB, victim_rd_idx SHALL be 0; when not asserted, fill_we, fill_idx, fill_data, mem_req, mem_we, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, k=0, and all registered outputs to 0 (busy=0, done=0, fill_we=0, mem_req=0); any in-flight transfer is abandoned with no further fill_we.
REQ-026 rst SHALL take priority over miss_req and mem_ack in the same cycle.

Verification
REQ-027 Clean miss, miss_addr=0x0000_1234, victim_dirty=0, mem_ack always 1 -> mem reads 0x1230, 0x1234, 0x1238, 0x123C; fill_idx 0..3 with matching mem_rdata; done at T+5.
REQ-028 Dirty miss, victim_addr=0x0000_8008, miss_addr=0x0000_0040 -> 4 writes to 0x8000..0x800C carrying victim words idx 0..3, then 4 reads 0x40..0x4C, done at T+9.
REQ-029 Wait states, mem_ack high every third cycle -> mem_addr/mem_wdata held stable between acks; exactly 4 fill_we pulses; done once.
REQ-030 miss_req held high through the refill -> second refill starts only from IDLE, the cycle after done; miss_req pulsed while busy is dropped.
REQ-031 rst asserted after the 2nd FILL ack -> next cycle busy=0, mem_req=0, fill_we=0; a fresh miss afterwards completes normally.
REQ-032 Spurious mem_ack in IDLE -> no state change, no fill_we.
